// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - round sequencer: loads an LFSR target onto b, ramps a at a prescaled rate
// and freezes a when the matcher raises stopSig.
module round_sequencer #(
  parameter int                 WIDTH      = 12,
  parameter int                 TICK_DIV   = 50000,
  parameter logic [WIDTH-1:0]   LFSR_SEED  = 12'hACE,
  parameter logic [WIDTH-1:0]   MIN_TARGET = 12'd100
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             stopSig,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             lfsr_fb;

  // Taps for x^12+x^11+x^10+x^4+1, shifting left with feedback into bit 0.
  assign lfsr_fb = lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    presc_d   = presc_q;
    running_d = running_q;
    done_d    = done_q;
    lfsr_d    = {lfsr_q[WIDTH-2:0], lfsr_fb};

    case (state_q)
      IDLE: begin
        if (start && !stopSig) state_d = LOAD;
      end
      LOAD: begin
        // Candidates below MIN_TARGET are skipped so a=0 can never match at round start.
        if (lfsr_q >= MIN_TARGET) begin
          b_d       = lfsr_q;
          a_d       = '0;
          presc_d   = '0;
          running_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stopSig) begin
          running_d = 1'b0;
          done_d    = 1'b1;
          state_d   = HALT;
        end else if (presc_q == TICK_LAST) begin
          presc_d = '0;
          a_d     = a_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      HALT: begin
        if (start && !stopSig) begin
          done_d  = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
